// File: rtl/vec_mac_stream_if.sv
// Stream bundle for vec_mac_stream: operand beats in, packet results out.
// The slave modport is the engine's view and the master modport is the
// operand-buffer / result-FIFO side that drives beats and accepts results.
interface vec_mac_stream_if #(
   parameter int C      = 8,
   parameter int W_X    = 8,
   parameter int W_K    = 8,
   parameter int W_BEAT = 8,
   parameter int W_Y    = 24
) ();

   // operand side
   logic                    s_valid;
   logic                    s_ready;
   logic                    s_last;
   logic [C-1:0][W_X-1:0]   x;
   logic [C-1:0][W_K-1:0]   k;

   // result side
   logic                    m_valid;
   logic                    m_ready;
   logic [W_Y-1:0]          m_y;
   logic                    m_sat;
   logic [W_BEAT-1:0]       m_beats;

   modport master (
      output s_valid, s_last, x, k, m_ready,
      input  s_ready, m_valid, m_y, m_sat, m_beats
   );

   modport slave (
      input  s_valid, s_last, x, k, m_ready,
      output s_ready, m_valid, m_y, m_sat, m_beats
   );

endinterface

// File: rtl/vec_mac_stream.sv
// Streaming signed dot-product engine.
// Each beat carries C lane pairs which are multiplied, reduced by a registered
// pairwise adder tree (one level per stage) and accumulated across beats until
// the beat flagged last. The packet sum is saturated to W_Y bits, flagged if
// clipped, and presented together with the packet's beat count.
// A single advance enable (output register empty or being drained) moves the
// whole pipeline, so a stalled result freezes every stage in place.
module vec_mac_stream #(
   parameter int C      = 8,
   parameter int W_X    = 8,
   parameter int W_K    = 8,
   parameter int W_BEAT = 8,
   parameter int W_Y    = 24
) (
   input  logic             clk,
   input  logic             rstn,
   vec_mac_stream_if.slave  bus
);

   localparam int DEPTH  = $clog2(C);
   localparam int C_PAD  = 1 << DEPTH;
   localparam int W_PROD = W_X + W_K;
   localparam int W_ACC  = W_X + W_K + DEPTH + W_BEAT;
   // all tree levels live in one flat array: level 0 (products) first,
   // then each halving level, ending with the single root node
   localparam int N_NODE = 2 * C_PAD - 1;

   // first node index of a tree level inside the flat node array
   function automatic int lvl_base(input int lvl);
      return 2 * C_PAD - 2 * (C_PAD >> lvl);
   endfunction

   logic                     adv_s;
   logic                     accept_s;
   logic signed [W_ACC-1:0]  prod_s [C_PAD];
   logic signed [W_ACC-1:0]  node_r [N_NODE];
   logic [DEPTH:0]           vld_r;
   logic [DEPTH:0]           last_r;

   logic signed [W_ACC-1:0]  tree_s;
   logic signed [W_ACC-1:0]  acc_r;
   logic signed [W_ACC-1:0]  acc_next_s;
   logic [W_BEAT-1:0]        cnt_r;
   logic [W_BEAT-1:0]        cnt_next_s;

   logic signed [W_Y-1:0]    y_sat_s;
   logic                     sat_s;

   logic                     m_valid_r;
   logic signed [W_Y-1:0]    m_y_r;
   logic                     m_sat_r;
   logic [W_BEAT-1:0]        m_beats_r;

   // the pipeline moves only when the output register is free or draining
   assign adv_s    = !m_valid_r || bus.m_ready;
   assign accept_s = bus.s_valid && adv_s;

   // per-lane signed products, sign-extended to accumulator width;
   // padding lanes up to the next power of two are tied to zero
   for (genvar i = 0; i < C_PAD; i++) begin : g_lane
      if (i < C) begin : g_real
         logic signed [W_PROD-1:0] p_s;
         assign p_s       = $signed(bus.x[i]) * $signed(bus.k[i]);
         assign prod_s[i] = {{(W_ACC - W_PROD){p_s[W_PROD-1]}}, p_s};
      end else begin : g_pad
         assign prod_s[i] = {W_ACC{1'b0}};
      end
   end

   // stage valid and last flags travel with their data and freeze on a stall
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_r  <= {(DEPTH + 1){1'b0}};
         last_r <= {(DEPTH + 1){1'b0}};
      end else if (adv_s) begin
         vld_r[0]  <= accept_s;
         last_r[0] <= bus.s_last;
         for (int l = 1; l <= DEPTH; l++) begin
            vld_r[l]  <= vld_r[l-1];
            last_r[l] <= last_r[l-1];
         end
      end
   end

   // product capture and adder-tree levels; plain data, qualified by vld_r
   always_ff @(posedge clk) begin
      if (adv_s) begin
         for (int j = 0; j < C_PAD; j++) begin
            node_r[j] <= prod_s[j];
         end
         for (int l = 1; l <= DEPTH; l++) begin
            for (int j = 0; j < (C_PAD >> l); j++) begin
               node_r[lvl_base(l) + j] <= node_r[lvl_base(l - 1) + 2 * j]
                                        + node_r[lvl_base(l - 1) + 2 * j + 1];
            end
         end
      end
   end

   assign tree_s     = node_r[N_NODE - 1];
   assign acc_next_s = acc_r + tree_s;
   assign cnt_next_s = cnt_r + W_BEAT'(1'b1);

   // clip the running packet sum into the W_Y output range
   if (W_Y >= W_ACC) begin : g_wide
      // output is wide enough: plain sign extension, never clipped
      always_comb begin
         y_sat_s = W_Y'(acc_next_s);
         sat_s   = 1'b0;
      end
   end else begin : g_narrow
      logic [W_ACC-W_Y:0] hi_s;
      // in range exactly when all bits from the output sign bit upward agree
      always_comb begin
         hi_s = acc_next_s[W_ACC-1:W_Y-1];
         if ((&hi_s) || !(|hi_s)) begin
            y_sat_s = acc_next_s[W_Y-1:0];
            sat_s   = 1'b0;
         end else if (acc_next_s[W_ACC-1]) begin
            y_sat_s = {1'b1, {(W_Y - 1){1'b0}}};
            sat_s   = 1'b1;
         end else begin
            y_sat_s = {1'b0, {(W_Y - 1){1'b1}}};
            sat_s   = 1'b1;
         end
      end
   end

   // accumulate tree sums across beats; on the last beat publish the result
   // and restart the accumulator for the next packet
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_r     <= {W_ACC{1'b0}};
         cnt_r     <= {W_BEAT{1'b0}};
         m_valid_r <= 1'b0;
         m_y_r     <= {W_Y{1'b0}};
         m_sat_r   <= 1'b0;
         m_beats_r <= {W_BEAT{1'b0}};
      end else if (adv_s) begin
         if (vld_r[DEPTH]) begin
            if (last_r[DEPTH]) begin
               m_valid_r <= 1'b1;
               m_y_r     <= y_sat_s;
               m_sat_r   <= sat_s;
               m_beats_r <= cnt_next_s;
               acc_r     <= {W_ACC{1'b0}};
               cnt_r     <= {W_BEAT{1'b0}};
            end else begin
               m_valid_r <= 1'b0;
               acc_r     <= acc_next_s;
               cnt_r     <= cnt_next_s;
            end
         end else begin
            m_valid_r <= 1'b0;
         end
      end
   end

   assign bus.s_ready = adv_s;
   assign bus.m_valid = m_valid_r;
   assign bus.m_y     = m_y_r;
   assign bus.m_sat   = m_sat_r;
   assign bus.m_beats = m_beats_r;

endmodule

// File: tb/tb_vec_mac_stream.sv
// Directed bench for vec_mac_stream: three builds (C=8/W_Y=24, C=8/W_Y=16,
// C=5/W_Y=24) driven with hand-computed vectors. Results are captured at each
// output handshake with the cycle they appeared, then compared in order.
module tb_vec_mac_stream;

   logic clk = 1'b0;
   logic rstn;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   vec_mac_stream_if #(.C(8), .W_X(8), .W_K(8), .W_BEAT(8), .W_Y(24)) bus_a ();
   vec_mac_stream_if #(.C(8), .W_X(8), .W_K(8), .W_BEAT(8), .W_Y(16)) bus_b ();
   vec_mac_stream_if #(.C(5), .W_X(8), .W_K(8), .W_BEAT(8), .W_Y(24)) bus_c ();

   vec_mac_stream #(.C(8), .W_X(8), .W_K(8), .W_BEAT(8), .W_Y(24)) u_dut_a (
      .clk(clk), .rstn(rstn), .bus(bus_a));
   vec_mac_stream #(.C(8), .W_X(8), .W_K(8), .W_BEAT(8), .W_Y(16)) u_dut_b (
      .clk(clk), .rstn(rstn), .bus(bus_b));
   vec_mac_stream #(.C(5), .W_X(8), .W_K(8), .W_BEAT(8), .W_Y(24)) u_dut_c (
      .clk(clk), .rstn(rstn), .bus(bus_c));

   typedef struct {
      longint y;
      longint sat;
      longint beats;
      int     cyc;
   } res_t;

   res_t q_a[$];
   res_t q_b[$];
   res_t q_c[$];
   int   acc_a = 0;
   int   acc_b = 0;
   int   acc_c = 0;

   // capture every completed result handshake with its cycle stamp
   always @(negedge clk) begin
      if (bus_a.m_valid && bus_a.m_ready)
         q_a.push_back('{longint'($signed(bus_a.m_y)), longint'(bus_a.m_sat),
                         longint'(bus_a.m_beats), cyc});
      if (bus_b.m_valid && bus_b.m_ready)
         q_b.push_back('{longint'($signed(bus_b.m_y)), longint'(bus_b.m_sat),
                         longint'(bus_b.m_beats), cyc});
      if (bus_c.m_valid && bus_c.m_ready)
         q_c.push_back('{longint'($signed(bus_c.m_y)), longint'(bus_c.m_sat),
                         longint'(bus_c.m_beats), cyc});
   end

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // pop the oldest captured result of one build and compare it
   task automatic expect_res(input int which, input string tag, input longint y,
                             input longint sat, input longint beats, input int lat);
      res_t r;
      int   sz;
      int   acc;
      case (which)
         0:       sz = q_a.size();
         1:       sz = q_b.size();
         default: sz = q_c.size();
      endcase
      check_eq({tag, "_present"}, longint'(sz > 0), 1);
      if (sz > 0) begin
         case (which)
            0:       begin r = q_a.pop_front(); acc = acc_a; end
            1:       begin r = q_b.pop_front(); acc = acc_b; end
            default: begin r = q_c.pop_front(); acc = acc_c; end
         endcase
         check_eq({tag, "_y"}, r.y, y);
         check_eq({tag, "_sat"}, r.sat, sat);
         check_eq({tag, "_beats"}, r.beats, beats);
         if (lat > 0) check_eq({tag, "_lat"}, longint'(r.cyc - acc + 1), longint'(lat));
      end
   endtask

   // offer one beat to a C=8 build and hold it until accepted (bounded)
   task automatic send8(input int which, input logic [7:0][7:0] xv,
                        input logic [7:0][7:0] kv, input logic last);
      int n = 0;
      if (which == 0) begin
         bus_a.x = xv; bus_a.k = kv; bus_a.s_last = last; bus_a.s_valid = 1'b1;
      end else begin
         bus_b.x = xv; bus_b.k = kv; bus_b.s_last = last; bus_b.s_valid = 1'b1;
      end
      @(negedge clk);
      while (((which == 0) ? !bus_a.s_ready : !bus_b.s_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("accept_wait", longint'(n < 50), 1);
      @(posedge clk);
      #1;
      if (which == 0) begin
         acc_a = cyc; bus_a.s_valid = 1'b0;
      end else begin
         acc_b = cyc; bus_b.s_valid = 1'b0;
      end
   endtask

   // offer one beat to the C=5 build
   task automatic send_c(input logic [4:0][7:0] xv, input logic [4:0][7:0] kv,
                         input logic last);
      bus_c.x = xv; bus_c.k = kv; bus_c.s_last = last; bus_c.s_valid = 1'b1;
      @(negedge clk);
      check_eq("c_ready", longint'(bus_c.s_ready), 1);
      @(posedge clk);
      #1;
      acc_c = cyc;
      bus_c.s_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0][7:0] xv;
      logic [7:0][7:0] kv;
      logic [4:0][7:0] xc;
      logic [4:0][7:0] kc;
      longint          ey;
      longint          es;
      int              held;
      longint          held_y;

      rstn = 1'b0;
      bus_a.s_valid = 1'b0; bus_a.s_last = 1'b0; bus_a.x = '0; bus_a.k = '0; bus_a.m_ready = 1'b1;
      bus_b.s_valid = 1'b0; bus_b.s_last = 1'b0; bus_b.x = '0; bus_b.k = '0; bus_b.m_ready = 1'b1;
      bus_c.s_valid = 1'b0; bus_c.s_last = 1'b0; bus_c.x = '0; bus_c.k = '0; bus_c.m_ready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_m_valid", longint'(bus_a.m_valid), 0);
      check_eq("rst_m_y", longint'(bus_a.m_y), 0);
      check_eq("rst_m_sat", longint'(bus_a.m_sat), 0);
      check_eq("rst_m_beats", longint'(bus_a.m_beats), 0);
      check_eq("rst_s_ready", longint'(bus_a.s_ready), 1);
      check_eq("rst_b_valid", longint'(bus_b.m_valid), 0);
      check_eq("rst_c_valid", longint'(bus_c.m_valid), 0);
      @(posedge clk);
      #2 rstn = 1'b1;
      idle(1);

      // single beat x={1..8}, k=1 -> 36 after 5 cycles
      for (int i = 0; i < 8; i++) begin xv[i] = 8'(i + 1); kv[i] = 8'd1; end
      send8(0, xv, kv, 1'b1);
      idle(10);
      expect_res(0, "t1", 36, 0, 1, 5);
      check_eq("t1_extra", longint'(q_a.size()), 0);

      // three back-to-back beats of 48 -> one result 144
      for (int i = 0; i < 8; i++) begin xv[i] = 8'd2; kv[i] = 8'd3; end
      for (int b = 0; b < 3; b++) send8(0, xv, kv, (b == 2));
      idle(12);
      expect_res(0, "t2", 144, 0, 3, 5);
      check_eq("t2_extra", longint'(q_a.size()), 0);

      // saturation and exact range boundaries on the W_Y=16 build
      for (int t = 0; t < 5; t++) begin
         xv = '0; kv = '0;
         case (t)
            0: begin
               for (int i = 0; i < 8; i++) begin xv[i] = 8'h80; kv[i] = 8'h80; end
               ey = 32767; es = 1;
            end
            1: begin
               for (int i = 0; i < 8; i++) begin xv[i] = 8'h80; kv[i] = 8'h7f; end
               ey = -32768; es = 1;
            end
            2: begin
               xv[0] = 8'd127; xv[1] = 8'd127; xv[2] = 8'd127; xv[3] = 8'd1;
               kv[0] = 8'd127; kv[1] = 8'd127; kv[2] = 8'd4;   kv[3] = 8'd1;
               ey = 32767; es = 0;
            end
            3: begin
               xv[0] = 8'd127; xv[1] = 8'd127; xv[2] = 8'd127; xv[3] = 8'd2;
               kv[0] = 8'd127; kv[1] = 8'd127; kv[2] = 8'd4;   kv[3] = 8'd1;
               ey = 32767; es = 1;
            end
            default: begin
               xv[0] = 8'h80; xv[1] = 8'h80; xv[2] = 8'h80;
               kv[0] = 8'd127; kv[1] = 8'd127; kv[2] = 8'd2;
               ey = -32768; es = 0;
            end
         endcase
         send8(1, xv, kv, 1'b1);
         idle(8);
         expect_res(1, $sformatf("t3_%0d", t), ey, es, 1, 5);
      end

      // backpressure: six single-beat packets, result side stalled 10 cycles
      bus_a.m_ready = 1'b0;
      held = 0;
      held_y = 0;
      fork
         begin
            logic [7:0][7:0] xp;
            logic [7:0][7:0] kp;
            for (int p = 0; p < 6; p++) begin
               for (int i = 0; i < 8; i++) begin xp[i] = 8'(p + 1); kp[i] = 8'd1; end
               send8(0, xp, kp, 1'b1);
            end
         end
         begin
            for (int s = 0; s < 10; s++) begin
               @(negedge clk);
               if (bus_a.m_valid) begin
                  check_eq("t4_sready", longint'(bus_a.s_ready), 0);
                  if (held != 0) check_eq("t4_hold", longint'($signed(bus_a.m_y)), held_y);
                  held = 1;
                  held_y = longint'($signed(bus_a.m_y));
               end
            end
            check_eq("t4_stalled", longint'(held), 1);
            @(posedge clk);
            #1 bus_a.m_ready = 1'b1;
         end
      join
      idle(20);
      check_eq("t4_count", longint'(q_a.size()), 6);
      for (int p = 0; p < 6; p++) expect_res(0, $sformatf("t4_%0d", p), longint'(8 * (p + 1)), 0, 1, 0);

      // reset in the middle of a packet discards the partial sum of 100
      xv = '0; xv[0] = 8'd50;
      for (int i = 0; i < 8; i++) kv[i] = 8'd1;
      send8(0, xv, kv, 1'b0);
      send8(0, xv, kv, 1'b0);
      @(posedge clk);
      #2 rstn = 1'b0;
      #2 rstn = 1'b1;
      idle(2);
      check_eq("t5_quiet", longint'(q_a.size()), 0);
      for (int i = 0; i < 8; i++) xv[i] = 8'd1;
      send8(0, xv, kv, 1'b1);
      idle(10);
      expect_res(0, "t5", 8, 0, 1, 5);
      check_eq("t5_extra", longint'(q_a.size()), 0);

      // C=5 build: padding lanes must contribute nothing
      for (int i = 0; i < 5; i++) begin xc[i] = 8'(i + 1); kc[i] = 8'(5 - i); end
      send_c(xc, kc, 1'b1);
      idle(10);
      expect_res(2, "t6", 35, 0, 1, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
